// File: rtl/spi_slave_if_if.sv
// SPI slave link bundle: serial pins plus the local rx/tx handshake.
// The master side drives the link and consumer controls; the slave side is the endpoint.
interface spi_slave_if_if #(
    parameter int WIDTH = 32
);
    logic             ss_n;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic             busy;
    logic             rx_overrun;
    logic             tx_underrun;
    logic             frame_err;

    modport master (
        output ss_n, sclk, mosi, rx_ack, tx_data, tx_load,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready,
        input  busy, rx_overrun, tx_underrun, frame_err
    );

    modport slave (
        input  ss_n, sclk, mosi, rx_ack, tx_data, tx_load,
        output miso, miso_oe, rx_data, rx_valid, tx_ready,
        output busy, rx_overrun, tx_underrun, frame_err
    );
endinterface

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave endpoint, fully in the clk domain with oversampled pins.
// Receives words into a valid/ack holding register and shifts a buffered word on MISO.
module spi_slave_if #(
    parameter int               WIDTH     = 32,
    parameter bit               LSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] DUMMY     = '1
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_if_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t           state;
    logic [1:0]       ss_s;
    logic [1:0]       sclk_s;
    logic [1:0]       mosi_s;
    logic             ss_d;
    logic             sclk_d;
    logic             mosi_d;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             ss_rise;
    logic             ss_fall;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    bit_cnt;
    logic             word_done;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // mosi gets the same 3-flop delay as the edge pulses so the
    // sampled bit lines up with the registered sclk_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_s      <= 2'b11;
            sclk_s    <= 2'b00;
            mosi_s    <= 2'b00;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b0;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            ss_s      <= {ss_s[0], bus.ss_n};
            sclk_s    <= {sclk_s[0], bus.sclk};
            mosi_s    <= {mosi_s[0], bus.mosi};
            ss_d      <= ss_s[1];
            sclk_d    <= sclk_s[1];
            mosi_d    <= mosi_s[1];
            sclk_rise <= sclk_s[1] & ~sclk_d;
            sclk_fall <= ~sclk_s[1] & sclk_d;
            ss_rise   <= ss_s[1] & ~ss_d;
            ss_fall   <= ~ss_s[1] & ss_d;
        end
    end

    always_comb begin
        rx_next   = LSB_FIRST ? {mosi_d, rx_shift[WIDTH-1:1]}
                              : {rx_shift[WIDTH-2:0], mosi_d};
        tx_next   = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
        load_word = bus.tx_ready ? DUMMY : tx_buf;
        word_done = (bit_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            rx_shift        <= '0;
            tx_shift        <= '0;
            tx_buf          <= '0;
            bus.miso        <= 1'b0;
            bus.miso_oe     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.tx_ready    <= 1'b1;
            bus.rx_overrun  <= 1'b0;
            bus.tx_underrun <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.tx_underrun <= 1'b0;
            bus.frame_err   <= 1'b0;
            if (bus.rx_ack) begin
                bus.rx_valid <= 1'b0;
            end
            if (bus.tx_load) begin
                tx_buf       <= bus.tx_data;
                bus.tx_ready <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state       <= LOAD;
                        bus.busy    <= 1'b1;
                        bus.miso_oe <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ss_rise) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.miso_oe <= 1'b0;
                        bus.miso    <= 1'b0;
                    end else begin
                        tx_shift        <= load_word;
                        bus.miso        <= head(load_word);
                        bus.tx_underrun <= bus.tx_ready;
                        bit_cnt         <= '0;
                        state           <= SHIFT;
                        // a same-cycle tx_load refills the buffer just drained
                        if (!bus.tx_load) begin
                            bus.tx_ready <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.miso_oe   <= 1'b0;
                        bus.miso      <= 1'b0;
                        bus.frame_err <= (bit_cnt != '0);
                        bit_cnt       <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (word_done) begin
                            bit_cnt <= '0;
                            state   <= LOAD;
                            if (!bus.rx_valid || bus.rx_ack) begin
                                bus.rx_data  <= rx_next;
                                bus.rx_valid <= 1'b1;
                            end else begin
                                bus.rx_overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt != '0) begin
                        // bit_cnt==0 here is the trailing fall of a finished word
                        tx_shift <= tx_next;
                        bus.miso <= head(tx_next);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frames plus randomized frames checked
// against a word-level model of the rx holding register and tx buffer.
`timescale 1ns/1ps
module tb_spi_slave_if;
    localparam int         W     = 32;
    localparam logic [W-1:0] DUMMY = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if_if #(.WIDTH(W)) b0 ();
    spi_slave_if_if #(.WIDTH(W)) b1 ();

    spi_slave_if #(.WIDTH(W), .LSB_FIRST(1'b0), .DUMMY(DUMMY)) dut (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    spi_slave_if #(.WIDTH(W), .LSB_FIRST(1'b1), .DUMMY(DUMMY)) dut_lsb (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    logic m_ss_n = 1'b1;
    logic m_sclk = 1'b0;
    logic m_mosi = 1'b0;
    logic sel    = 1'b0;

    assign b0.ss_n = sel ? 1'b1 : m_ss_n;
    assign b0.sclk = sel ? 1'b0 : m_sclk;
    assign b0.mosi = m_mosi;
    assign b1.ss_n = sel ? m_ss_n : 1'b1;
    assign b1.sclk = sel ? m_sclk : 1'b0;
    assign b1.mosi = m_mosi;
    assign b1.rx_ack  = 1'b0;
    assign b1.tx_load = 1'b0;
    assign b1.tx_data = '0;

    wire miso_m  = sel ? b1.miso : b0.miso;
    wire busy_m  = sel ? b1.busy : b0.busy;
    wire ready_m = sel ? b1.tx_ready : b0.tx_ready;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int un_cnt = 0;
    int rv_cnt = 0;
    int rv_cyc = 0;
    int last_rise = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b0.frame_err) fe_cnt++;
        if (b0.tx_underrun) un_cnt++;
        if (b0.rx_valid && !rv_prev) begin
            rv_cnt++;
            rv_cyc = cyc;
        end
        rv_prev = b0.rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(output logic ready_in_load);
        int t;
        m_ss_n = 1'b0;
        t = 0;
        while (!busy_m && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", W'(t < 40), W'(1));
        ready_in_load = ready_m;
        tick(1);
        check("tx_ready_after_load", W'(ready_m), W'(1));
        tick(4);
    endtask

    task automatic xfer(input logic [W-1:0] mw, input int nbits,
                        output logic [W-1:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            m_mosi = mw[W-1-i];
            tick(4);
            m_sclk = 1'b1;
            cap[W-1-i] = miso_m;
            last_rise = cyc;
            tick(4);
            m_sclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        tick(4);
        m_ss_n = 1'b1;
        tick(10);
    endtask

    task automatic ack();
        b0.rx_ack = 1'b1;
        tick(1);
        b0.rx_ack = 1'b0;
        tick(1);
    endtask

    task automatic load(input logic [W-1:0] v);
        b0.tx_data = v;
        b0.tx_load = 1'b1;
        tick(1);
        b0.tx_load = 1'b0;
        tick(1);
    endtask

    logic [W-1:0] cap;
    logic         rl;
    int           fe0, un0, un1, rv0;
    logic         m_valid, m_over, m_full;
    logic [W-1:0] m_data, m_buf, m_tx, w;
    int           m_under, nw;

    initial begin
        b0.rx_ack  = 1'b0;
        b0.tx_load = 1'b0;
        b0.tx_data = '0;
        tick(3);
        check("rst_miso", W'(b0.miso), W'(0));
        check("rst_miso_oe", W'(b0.miso_oe), W'(0));
        check("rst_rx_data", b0.rx_data, W'(0));
        check("rst_rx_valid", W'(b0.rx_valid), W'(0));
        check("rst_tx_ready", W'(b0.tx_ready), W'(1));
        check("rst_busy", W'(b0.busy), W'(0));
        check("rst_overrun", W'(b0.rx_overrun), W'(0));
        check("rst_underrun", W'(b0.tx_underrun), W'(0));
        check("rst_frame_err", W'(b0.frame_err), W'(0));
        rst = 1'b0;
        tick(2);

        fe0 = fe_cnt;
        frame_begin(rl);
        xfer(32'hA5C3_0F81, 32, cap);
        tick(1);
        check("single_rx_data", b0.rx_data, 32'hA5C3_0F81);
        check("single_rx_valid", W'(b0.rx_valid), W'(1));
        check("single_latency", W'(rv_cyc - last_rise), W'(4));
        check("single_miso_dummy", cap, DUMMY);
        frame_end();
        check("single_no_ferr", W'(fe_cnt - fe0), W'(0));
        check("single_no_overrun", W'(b0.rx_overrun), W'(0));
        check("single_idle", W'(b0.busy), W'(0));
        ack();
        check("ack_clears", W'(b0.rx_valid), W'(0));

        load(32'h1234_5678);
        check("tx_ready_full", W'(b0.tx_ready), W'(0));
        frame_begin(rl);
        check("tx_ready_in_load", W'(rl), W'(0));
        xfer(32'h0F0F_0F0F, 32, cap);
        check("tx_miso_word", cap, 32'h1234_5678);
        tick(1);
        check("tx_rx_data", b0.rx_data, 32'h0F0F_0F0F);
        frame_end();
        ack();

        load(32'hCAFE_F00D);
        rv0 = rv_cnt;
        frame_begin(rl);
        un0 = un_cnt;
        xfer(32'h0000_0001, 32, cap);
        tick(1);
        check("b2b_w1_rx", b0.rx_data, 32'h0000_0001);
        check("b2b_w1_miso", cap, 32'hCAFE_F00D);
        ack();
        xfer(32'hFFFF_0000, 32, cap);
        un1 = un_cnt;
        check("b2b_underrun_once", W'(un1 - un0), W'(1));
        check("b2b_w2_miso", cap, DUMMY);
        tick(1);
        check("b2b_w2_rx", b0.rx_data, 32'hFFFF_0000);
        check("b2b_two_events", W'(rv_cnt - rv0), W'(2));
        frame_end();
        ack();

        frame_begin(rl);
        xfer(32'h1111_1111, 32, cap);
        xfer(32'h2222_2222, 32, cap);
        tick(1);
        check("ovr_rx_data", b0.rx_data, 32'h1111_1111);
        check("ovr_flag", W'(b0.rx_overrun), W'(1));
        check("ovr_valid", W'(b0.rx_valid), W'(1));
        frame_end();
        ack();
        frame_begin(rl);
        xfer(32'h3333_3333, 32, cap);
        tick(1);
        check("ovr_next_rx", b0.rx_data, 32'h3333_3333);
        check("ovr_sticky", W'(b0.rx_overrun), W'(1));
        frame_end();
        ack();

        fe0 = fe_cnt;
        frame_begin(rl);
        xfer(32'h5555_5555, 13, cap);
        frame_end();
        check("abort_ferr_once", W'(fe_cnt - fe0), W'(1));
        check("abort_no_valid", W'(b0.rx_valid), W'(0));
        check("abort_idle", W'(b0.busy), W'(0));
        check("abort_rx_kept", b0.rx_data, 32'h3333_3333);
        frame_begin(rl);
        xfer(32'hDEAD_BEEF, 32, cap);
        tick(1);
        check("abort_next_rx", b0.rx_data, 32'hDEAD_BEEF);
        frame_end();
        ack();

        fe0 = fe_cnt;
        frame_begin(rl);
        xfer(32'h0123_4567, 20, cap);
        rst = 1'b1;
        m_ss_n = 1'b1;
        tick(3);
        check("mrst_busy", W'(b0.busy), W'(0));
        check("mrst_miso_oe", W'(b0.miso_oe), W'(0));
        check("mrst_miso", W'(b0.miso), W'(0));
        check("mrst_rx_valid", W'(b0.rx_valid), W'(0));
        check("mrst_rx_data", b0.rx_data, W'(0));
        check("mrst_tx_ready", W'(b0.tx_ready), W'(1));
        check("mrst_overrun", W'(b0.rx_overrun), W'(0));
        rst = 1'b0;
        tick(4);
        check("mrst_no_ferr", W'(fe_cnt - fe0), W'(0));
        frame_begin(rl);
        xfer(32'h5A5A_5A5A, 32, cap);
        tick(1);
        check("mrst_next_rx", b0.rx_data, 32'h5A5A_5A5A);
        frame_end();
        ack();

        sel = 1'b1;
        tick(2);
        frame_begin(rl);
        xfer(32'h8000_0000, 32, cap);
        tick(1);
        check("lsb_rx_data", b1.rx_data, 32'h0000_0001);
        check("lsb_rx_valid", W'(b1.rx_valid), W'(1));
        check("lsb_miso_dummy", cap, DUMMY);
        frame_end();
        sel = 1'b0;
        tick(2);

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_full  = 1'b0;
        m_data  = '0;
        m_buf   = '0;
        m_tx    = '0;
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                ack();
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom();
                load(w);
                m_buf  = w;
                m_full = 1'b1;
            end
            fe0 = fe_cnt;
            un0 = un_cnt;
            m_under = 0;
            m_tx = m_full ? m_buf : DUMMY;
            if (!m_full) m_under++;
            m_full = 1'b0;
            frame_begin(rl);
            for (int j = 0; j < nw; j++) begin
                if (j > 0 && $urandom_range(0, 1) == 1) begin
                    ack();
                    m_valid = 1'b0;
                end
                if (j > 0 && $urandom_range(0, 1) == 1) begin
                    w = $urandom();
                    load(w);
                    m_buf  = w;
                    m_full = 1'b1;
                end
                w = $urandom();
                xfer(w, 32, cap);
                check("rnd_miso", cap, m_tx);
                if (!m_valid) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
                m_tx = m_full ? m_buf : DUMMY;
                if (!m_full) m_under++;
                m_full = 1'b0;
                tick(1);
                check("rnd_rx_data", b0.rx_data, m_data);
                check("rnd_rx_valid", W'(b0.rx_valid), W'(m_valid));
                check("rnd_overrun", W'(b0.rx_overrun), W'(m_over));
            end
            frame_end();
            check("rnd_underruns", W'(un_cnt - un0), W'(m_under));
            check("rnd_no_ferr", W'(fe_cnt - fe0), W'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave endpoint: the far end of the SoC's SPI master link (ssS, sclkS, mosiS, misoS). Lets a peripheral model or a second SoC tile receive command words from the master and return status words.
- Runs entirely in the local system clock domain. The SPI pins are oversampled through synchronizers.
- Receives full-length words into a holding register with a valid/ack handshake, and shifts a preloaded transmit word out on MISO.
- Mode 0 framing: CPOL=0, CPHA=0. Matches the master configured with rx_neg=0, tx_neg=1.

Parameters:
- WIDTH, 32: bits per SPI character. Legal range 8..128.
- LSB_FIRST, 0: 0 = MSB shifted first on both MOSI and MISO; 1 = LSB first.
- DUMMY, all-ones of WIDTH: word driven on MISO when no transmit word is loaded.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ss_n  in  1  slave select from master, active low, asynchronous to clk.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  MISO output enable; high only while the slave is selected.
- rx_data  out  WIDTH  last completed received word.
- rx_valid  out  1  rx_data holds an unread word (level signal).
- rx_ack  in  1  consumer accepts rx_data; clears rx_valid.
- tx_data  in  WIDTH  next word to transmit.
- tx_load  in  1  one-cycle strobe that writes tx_data into the transmit buffer.
- tx_ready  out  1  transmit buffer is empty and can accept tx_load.
- busy  out  1  a frame is in progress.
- rx_overrun  out  1  sticky: a word completed while rx_valid was high.
- tx_underrun  out  1  one-cycle pulse: a word started with the transmit buffer empty.
- frame_err  out  1  one-cycle pulse: ss_n deasserted mid-word.

Behaviour:
- Reset: every output is 0 except tx_ready=1 and miso=0. The transmit buffer, shift registers and bit counter are cleared; the FSM goes to IDLE. A reset mid-frame abandons the frame silently, with no frame_err.
- Synchronizers: ss_n, sclk and mosi each pass through 2 flops. Edges are detected on the synchronized sclk and ss_n using a third flop.
- Clock ratio: clk must be ≥4× the sclk frequency, and each sclk phase must last ≥2 clk periods. Behaviour outside this range is undefined.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: busy=0, miso_oe=0. A falling edge on synchronized ss_n moves to LOAD.
  - LOAD (1 cycle): tx_shift takes the transmit buffer if it is full, otherwise DUMMY (and tx_underrun pulses). The buffer is marked empty, so tx_ready=1 next cycle. bit_cnt=0. miso presents the first bit (MSB, or LSB if LSB_FIRST=1). miso_oe=1, busy=1. Then go to SHIFT.
  - SHIFT, rising sclk: rx_shift captures synchronized mosi; bit_cnt increments.
  - SHIFT, falling sclk: tx_shift advances and miso presents the next bit. No advance occurs after the final bit of a word.
  - SHIFT, word complete (bit_cnt reaches WIDTH on a rising edge):
    - If rx_valid=0: rx_data is updated with the assembled word and rx_valid is set.
    - If rx_valid=1: rx_data is kept, rx_overrun is set, and the new word is dropped.
    - Either way, go to LOAD for the next word in the same frame. The next word's first bit appears on miso before the next falling sclk.
  - SHIFT, ss_n rising edge: go to IDLE. If bit_cnt≠0, pulse frame_err and discard the partial word (rx_data unchanged). If bit_cnt=0, it is a clean frame end.
- Latency: rx_valid rises exactly 4 clk cycles after the rising sclk edge of the final bit (2 synchronizer cycles, 1 edge-detect cycle, 1 register cycle).
- rx handshake: rx_ack while rx_valid=1 clears rx_valid next cycle. rx_ack while rx_valid=0 is ignored. If rx_ack and a word completion occur in the same cycle, the new word is stored, rx_valid stays 1, and no overrun is flagged.
- tx buffer:
  - tx_load while tx_ready=1 stores tx_data and clears tx_ready.
  - tx_load while tx_ready=0 overwrites the buffered word (last write wins).
  - tx_load in the same cycle as LOAD: LOAD consumes the old buffer contents, and the new word is stored, leaving tx_ready=0.
- rx_overrun clears only on rst.
- miso is forced to 0 whenever miso_oe=0.

Test Plan:
- Single-word receive: rst, then one frame with mosi=0xA5C3_0F81, MSB first, sclk = clk/8 → rx_data=0xA5C30F81. rx_valid rises 4 clk after the 32nd rising sclk. No errors.
- Transmit: tx_load with 0x1234_5678 before ss_n falls; master clocks 32 bits → master captures 0x12345678 on miso. tx_ready returns high the cycle after LOAD.
- Back-to-back frame: one ss_n frame carrying 0x0000_0001 then 0xFFFF_0000, with rx_ack pulsed between words → two rx_valid events with those values. Second word with tx buffer empty → miso=DUMMY and tx_underrun pulses once.
- Overrun: two words received with no rx_ack → rx_data=first word, rx_overrun=1 and stays 1 until rst.
- Aborted frame: ss_n rises after 13 bits → frame_err pulses once, rx_valid stays 0, FSM returns to IDLE. A following full word 0xDEAD_BEEF is received correctly.
- Reset mid-frame: rst asserted at bit 20 → all outputs return to reset values, no frame_err. A subsequent frame works; LSB_FIRST=1 build receives bits 1,0,0,… as 0x00000001.
